// File: rtl/kernel_alarm_output.sv
// Avalon-MM alarm output port: static levels plus per-channel timed pulses.
// Optional atomic SET/CLEAR registers at word addresses 4/5: KERNEL_ALARM_OUTPUT_SETCLR_EN.
module kernel_alarm_output #(
  parameter int          WIDTH      = 4,
  parameter int          PW_BITS    = 16,
  parameter int unsigned PW_DEFAULT = 100
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [2:0]       address,
  input  logic             chipselect,
  input  logic             write_n,
  input  logic [31:0]      writedata,
  output logic [31:0]      readdata,
  output logic [WIDTH-1:0] out_port
);

  localparam logic [2:0] ADDR_DATA  = 3'd0;
  localparam logic [2:0] ADDR_PW    = 3'd1;
  localparam logic [2:0] ADDR_TRIG  = 3'd2;
  localparam logic [2:0] ADDR_ABORT = 3'd3;
`ifdef KERNEL_ALARM_OUTPUT_SETCLR_EN
  localparam logic [2:0] ADDR_SET   = 3'd4;
  localparam logic [2:0] ADDR_CLR   = 3'd5;
`endif

  // Bus handshake: a write is accepted on any edge where chipselect=1 and
  // write_n=0 (zero wait states); reads need no strobe and readdata follows
  // the address one cycle later.
  logic               wr_en;
  logic [WIDTH-1:0]   wd;
  logic [WIDTH-1:0]   data_reg;
  logic [WIDTH-1:0]   data_next;
  logic [WIDTH-1:0]   active;
  logic [PW_BITS-1:0] pw_reg;
  logic [PW_BITS-1:0] cnt [WIDTH];
  logic [31:0]        rd_next;
  logic               unused_wd;

  assign wr_en     = chipselect & ~write_n;
  assign wd        = writedata[WIDTH-1:0];
  assign unused_wd = ^writedata;

  always_comb begin
    for (int i = 0; i < WIDTH; i++) begin
      active[i] = (cnt[i] != '0);
    end
  end

  always_comb begin
    data_next = data_reg;
    if (wr_en) begin
      case (address)
        ADDR_DATA: data_next = wd;
`ifdef KERNEL_ALARM_OUTPUT_SETCLR_EN
        ADDR_SET:  data_next = data_reg | wd;
        ADDR_CLR:  data_next = data_reg & ~wd;
`endif
        default:   data_next = data_reg;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      data_reg <= '0;
      pw_reg   <= PW_BITS'(PW_DEFAULT);
    end else begin
      data_reg <= data_next;
      if (wr_en && address == ADDR_PW) pw_reg <= writedata[PW_BITS-1:0];
    end
  end

  // Trigger reloads (extending a running pulse); a zero width is ignored so
  // it can neither start nor cut short a pulse.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < WIDTH; i++) cnt[i] <= '0;
    end else begin
      for (int i = 0; i < WIDTH; i++) begin
        if (wr_en && address == ADDR_TRIG && wd[i] && pw_reg != '0)
          cnt[i] <= pw_reg;
        else if (wr_en && address == ADDR_ABORT && wd[i])
          cnt[i] <= '0;
        else if (cnt[i] != '0)
          cnt[i] <= cnt[i] - PW_BITS'(1);
      end
    end
  end

  always_comb begin
    rd_next = '0;
    case (address)
      ADDR_DATA:  rd_next[WIDTH-1:0]   = data_reg;
      ADDR_PW:    rd_next[PW_BITS-1:0] = pw_reg;
      ADDR_TRIG:  rd_next[WIDTH-1:0]   = active;
      ADDR_ABORT: rd_next[WIDTH-1:0]   = out_port;
`ifdef KERNEL_ALARM_OUTPUT_SETCLR_EN
      ADDR_SET:   rd_next[WIDTH-1:0]   = data_reg;
      ADDR_CLR:   rd_next[WIDTH-1:0]   = data_reg;
`endif
      default:    rd_next = '0;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      out_port <= '0;
      readdata <= '0;
    end else begin
      out_port <= data_reg | active;
      readdata <= rd_next;
    end
  end

endmodule

// File: tb/tb_kernel_alarm_output.sv
// Scoreboarded bench for kernel_alarm_output: directed plan plus random bus traffic
// checked against a pulse-end-time reference model.
module tb_kernel_alarm_output;

  localparam int W = 4;

  logic          clk;
  logic          reset_n;
  logic [2:0]    address;
  logic          chipselect;
  logic          write_n;
  logic [31:0]   writedata;
  logic [31:0]   readdata;
  logic [W-1:0]  out_port;

  kernel_alarm_output #(.WIDTH(W), .PW_BITS(16), .PW_DEFAULT(100)) dut (
    .clk(clk), .reset_n(reset_n), .address(address), .chipselect(chipselect),
    .write_n(write_n), .writedata(writedata), .readdata(readdata), .out_port(out_port)
  );

  // clock / reset
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int checks = 0;
  int errors = 0;

  // expected {readdata, out_port} after each edge
  logic [32+W-1:0] exp_q[$];

  // reference model: a pulse is described by the last edge number it covers
  longint        edge_n;
  longint        end_m [W];
  logic [W-1:0]  data_m;
  int unsigned   pw_m;
  logic [W-1:0]  cur_out_m;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [W-1:0] act_mask(input longint k);
    logic [W-1:0] m;
    for (int i = 0; i < W; i++) m[i] = (k < end_m[i]);
    return m;
  endfunction

  function automatic logic [31:0] read_model(input logic [2:0] a, input longint k);
    logic [31:0] r;
    r = '0;
    case (a)
      3'd0: r[W-1:0] = data_m;
      3'd1: r = {16'd0, pw_m[15:0]};
      3'd2: r[W-1:0] = act_mask(k);
      3'd3: r[W-1:0] = cur_out_m;
`ifdef KERNEL_ALARM_OUTPUT_SETCLR_EN
      3'd4, 3'd5: r[W-1:0] = data_m;
`endif
      default: r = '0;
    endcase
    return r;
  endfunction

  task automatic model_reset();
    data_m    = '0;
    pw_m      = 100;
    cur_out_m = '0;
    for (int i = 0; i < W; i++) end_m[i] = 0;
    exp_q.delete();
  endtask

  task automatic do_reset();
    @(negedge clk);
    chipselect = 1'b0;
    write_n    = 1'b1;
    reset_n    = 1'b0;
    #1;
    chk("reset_out_port", {28'd0, out_port}, 32'd0);
    chk("reset_readdata", readdata, 32'd0);
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    model_reset();
  endtask

  // driver: one bus cycle, issued at the falling edge
  task automatic bus_cycle(input bit cs, input bit wn, input logic [2:0] a, input logic [31:0] d);
    logic [W-1:0] out_e;
    logic [31:0]  rd_e;
    logic [W-1:0] dm;
    @(negedge clk);
    edge_n = edge_n + 1;
    out_e  = data_m | act_mask(edge_n - 1);
    rd_e   = read_model(a, edge_n - 1);
    exp_q.push_back({rd_e, out_e});
    chipselect = cs;
    write_n    = wn;
    address    = a;
    writedata  = d;
    dm = d[W-1:0];
    if (cs && !wn) begin
      case (a)
        3'd0: data_m = dm;
        3'd1: pw_m = {16'd0, d[15:0]};
        3'd2: if (pw_m != 0)
                for (int i = 0; i < W; i++) if (dm[i]) end_m[i] = edge_n + longint'(pw_m);
        3'd3: for (int i = 0; i < W; i++) if (dm[i] && end_m[i] > edge_n) end_m[i] = edge_n;
`ifdef KERNEL_ALARM_OUTPUT_SETCLR_EN
        3'd4: data_m = data_m | dm;
        3'd5: data_m = data_m & ~dm;
`endif
        default: ;
      endcase
    end
    cur_out_m = out_e;
  endtask

  task automatic wr(input logic [2:0] a, input logic [31:0] d);
    bus_cycle(1'b1, 1'b0, a, d);
  endtask

  task automatic idle(input logic [2:0] a, input int n);
    for (int i = 0; i < n; i++) bus_cycle(1'b0, 1'($urandom_range(0, 1)), a, $urandom);
  endtask

  // monitor / scoreboard
  initial begin
    logic [32+W-1:0] e;
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        chk("out_port", {28'd0, out_port}, {28'd0, e[W-1:0]});
        chk("readdata", readdata, e[32+W-1:W]);
      end
    end
  end

  initial begin
    reset_n    = 1'b1;
    chipselect = 1'b0;
    write_n    = 1'b1;
    address    = 3'd0;
    writedata  = '0;
    edge_n     = 0;
    model_reset();
    #2 reset_n = 1'b0;
    do_reset();

    idle(3'd1, 3);
    wr(3'd0, 32'hFFFF_FFF5);         // upper bits ignored
    idle(3'd0, 3);
    wr(3'd0, 32'h0);
    wr(3'd1, 32'hABCD_0003);
    wr(3'd2, 32'h2);
    idle(3'd2, 6);
    wr(3'd1, 32'd10);
    wr(3'd2, 32'h1);
    idle(3'd3, 4);
    wr(3'd2, 32'h1);                 // re-trigger extends
    idle(3'd2, 18);
    wr(3'd2, 32'h1);
    idle(3'd2, 3);
    wr(3'd3, 32'h1);                 // abort mid pulse
    idle(3'd3, 3);
    wr(3'd1, 32'd0);
    wr(3'd2, 32'hF);                 // zero width ignored
    idle(3'd2, 3);
    wr(3'd0, 32'h8);
    wr(3'd1, 32'd4);
    wr(3'd2, 32'h8);
    idle(3'd3, 1);
    wr(3'd3, 32'h8);
    idle(3'd3, 6);
    wr(3'd1, 32'd10);
    wr(3'd2, 32'hF);
    idle(3'd2, 3);
    do_reset();                      // reset mid pulse
    idle(3'd2, 12);
    wr(3'd0, 32'h3);
    wr(3'd4, 32'h4);
    wr(3'd5, 32'h1);
    idle(3'd4, 2);
    idle(3'd5, 1);
    wr(3'd6, 32'hF);
    wr(3'd7, 32'hF);
    idle(3'd6, 1);
    idle(3'd7, 1);

    for (int n = 0; n < 500; n++) begin
      logic [2:0]  a;
      logic [31:0] d;
      a = 3'($urandom_range(0, 7));
      d = $urandom;
      if (a == 3'd1) d = {d[31:16], 16'($urandom_range(0, 12))};
      bus_cycle(1'($urandom_range(0, 2) != 0), 1'($urandom_range(0, 1)), a, d);
    end

    idle(3'd0, 2);
    @(negedge clk);
    chk("queue_drained", exp_q.size(), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/kernel_alarm_output.md
Name: kernel_alarm_output

Overview:
- Avalon-MM slave output port that drives the alarm lines sampled by the alarm input/edge-capture PIO on the other side of the board.
- Software sets static levels and fires fixed-width timed pulses per channel, so edge-capture logic sees clean rising edges of known duration.
- Sits on the kernel Avalon bus next to the existing PIO slaves; all outputs are registered.

Parameters:
- WIDTH, 4, number of alarm channels (bits of out_port), 1..16
- PW_BITS, 16, width of pulse-width register and per-channel down-counters
- PW_DEFAULT, 100, reset value of pulse-width register (clk cycles)

Ports:
- clk  input  1  system clock
- reset_n  input  1  asynchronous active-low reset
- address  input  3  register select (word address)
- chipselect  input  1  slave select
- write_n  input  1  active-low write strobe, qualified by chipselect
- writedata  input  32  write data
- readdata  output  32  registered read data, upper unused bits zero
- out_port  output  WIDTH  registered alarm outputs

Behaviour:
- One clock, asynchronous active-low reset (clk, reset_n). Reset: out_port=0, readdata=0, data_reg=0, pw_reg=PW_DEFAULT, all counters=0.
- Write strobe = chipselect & ~write_n; zero wait states; takes effect on that clock edge.
- Register map:
  - 0 DATA RW: data_reg <= writedata[WIDTH-1:0].
  - 1 PULSE_WIDTH RW: pw_reg <= writedata[PW_BITS-1:0].
  - 2 TRIGGER W: each 1 bit loads that channel's counter with pw_reg. Read returns active mask (counter != 0 per bit).
  - 3 ABORT W: each 1 bit clears that channel's counter to 0. Read returns current out_port.
  - 4/5 SET/CLEAR: see Optional Feature. Otherwise writes are ignored and reads return 0.
  - 6, 7: writes ignored, read 0.
- readdata is updated every clock from the address mux, no read strobe: 1-cycle read latency.
- Counters decrement by 1 each clock while nonzero, saturating at 0.
- out_port[i] <= data_reg[i] | (cnt[i] != 0), registered.
- Trigger written at edge N: out_port[i] is high for exactly pw_reg cycles, first high cycle after edge N+1.
- Trigger while channel active: counter reloads with pw_reg. Pulse extends, no low glitch.
- Trigger with pw_reg=0: ignored, channel stays inactive.
- pw_reg write during active pulse: running counters unaffected, new value applies to later triggers only.
- Abort on inactive channel: no effect. Abort does not alter data_reg; a channel with data_reg=1 stays high.
- Reset asserted mid-pulse: everything returns to reset values immediately; no pulse resumes on release.
- WIDTH<32: writedata bits above WIDTH/PW_BITS are ignored.

Optional Feature:
- Macro KERNEL_ALARM_OUTPUT_SETCLR_EN.
- Defined:
  - Addr 4 SET W: data_reg <= data_reg | writedata[WIDTH-1:0].
  - Addr 5 CLEAR W: data_reg <= data_reg & ~writedata[WIDTH-1:0].
  - Reads of 4/5 return data_reg.
  - Gives atomic per-bit updates with no read-modify-write.
- Undefined: addresses 4/5 behave as reserved (writes ignored, reads 0). No set/clear logic is synthesized.

Test Plan:
- Reset, then read addr 1 -> readdata=100 one cycle after address presented; out_port=0.
- Write DATA=0x5 -> out_port=0x5 next cycle; read addr 0 -> 0x5.
- Write PULSE_WIDTH=3, TRIGGER=0x2 -> out_port[1] high exactly 3 cycles starting the cycle after the write edge; addr 2 reads 0x2 during the pulse, then 0x0.
- PULSE_WIDTH=10, TRIGGER=0x1, re-trigger at cycle 5 -> out_port[0] high continuously for 15 cycles. ABORT=0x1 during a pulse -> low next cycle. PULSE_WIDTH=0 then TRIGGER -> no pulse.
- DATA=0x8, PULSE_WIDTH=4, TRIGGER=0x8, ABORT=0x8 -> out_port[3] stays 1 throughout. Assert reset_n mid-pulse -> out_port=0 asynchronously and stays 0 after release.
- With KERNEL_ALARM_OUTPUT_SETCLR_EN defined: DATA=0x3, SET=0x4, CLEAR=0x1 -> out_port=0x6, addr 4 reads 0x6. Without the macro: same writes leave out_port=0x3, addr 4 reads 0.
